servo_pwm_axi_multi: RTL

- Parametrised multi-channel servo PWM generator with an AXI4-Lite slave register interface (S00_AXI).
- All channels share one frame counter and one period. Each channel has its own pulse width and enable.
- Period and pulse writes go to shadow registers. They take effect only at the frame boundary, so pulses are never glitched mid-frame.
- A sticky frame-done flag with optional interrupt lets software pace updates. Packaged as IP in the block design next to the existing servo_axi.

---
 rtl/servo_pwm_axi_multi.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/servo_pwm_axi_multi.sv
// servo_pwm_axi_multi
// Multi-channel servo PWM generator behind an AXI4-Lite slave (S00_AXI).
// All channels share one frame counter and period. Each channel has its own
// pulse width and enable. Period, pulse and enable writes land in shadow
// registers and are copied to the active set only when the frame wraps.
//
// Ports:
//   ACLK, ARESETN          clock, asynchronous active-low reset
//   s00_axi_aw*/w*/b*      AXI4-Lite write address / data / response
//   s00_axi_ar*/r*         AXI4-Lite read address / data
//   pwm_out[NUM_CH-1:0]    registered servo pulse outputs
//   irq                    registered level interrupt (FRAME_DONE & IRQ_EN)
module servo_pwm_axi_multi #(
    parameter int NUM_CH               = 4,
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 6,
    parameter int CNT_WIDTH            = 24,
    parameter int DEFAULT_PERIOD       = 2000000,
    parameter int PULSE_MIN            = 50000,
    parameter int PULSE_MAX            = 250000
) (
    input  logic                                ACLK,
    input  logic                                ARESETN,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                          s00_axi_awprot,
    input  logic                                s00_axi_awvalid,
    output logic                                s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [(C_S00_AXI_DATA_WIDTH/8)-1:0] s00_axi_wstrb,
    input  logic                                s00_axi_wvalid,
    output logic                                s00_axi_wready,
    output logic [1:0]                          s00_axi_bresp,
    output logic                                s00_axi_bvalid,
    input  logic                                s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                          s00_axi_arprot,
    input  logic                                s00_axi_arvalid,
    output logic                                s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                          s00_axi_rresp,
    output logic                                s00_axi_rvalid,
    input  logic                                s00_axi_rready,
    output logic [NUM_CH-1:0]                   pwm_out,
    output logic                                irq
);

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    localparam cnt_t P_MIN   = cnt_t'(PULSE_MIN);
    localparam cnt_t P_MAX   = cnt_t'(PULSE_MAX);
    localparam cnt_t P_DEF   = cnt_t'(DEFAULT_PERIOD);
    localparam cnt_t P_FLOOR = cnt_t'(2);

    logic                            aw_rdy, ar_rdy, b_vld, r_vld;
    logic [C_S00_AXI_DATA_WIDTH-1:0] r_data, rd_mux;
    logic [NUM_CH-1:0]               ctrl_en, en_act, ctrl_en_new, pwm_q;
    logic                            irq_en, irq_en_new, frame_done, irq_q;
    cnt_t                            period_sh, period_act, period_new, cnt;
    cnt_t                            pulse_sh  [NUM_CH];
    cnt_t                            pulse_act [NUM_CH];
    cnt_t                            pulse_old, pulse_new;
    int unsigned                     wr_word, rd_word;
    logic                            wr_fire, rd_fire, wrap, status_clr;
    logic                            unused_ok;

    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                         s00_axi_araddr[1:0], s00_axi_wdata, s00_axi_wstrb};

    // Byte-lane merge restricted to the CNT_WIDTH bits that exist; upper wdata bits are dropped.
    function automatic cnt_t merge_cnt(input cnt_t old_v,
                                       input logic [C_S00_AXI_DATA_WIDTH-1:0] data,
                                       input logic [(C_S00_AXI_DATA_WIDTH/8)-1:0] strb);
        cnt_t r;
        r = old_v;
        for (int unsigned j = 0; j < CNT_WIDTH; j++) begin
            if (strb[j/8]) r[j] = data[j];
        end
        return r;
    endfunction

    function automatic cnt_t clamp_pulse(input cnt_t v);
        if (v < P_MIN) return P_MIN;
        if (v > P_MAX) return P_MAX;
        return v;
    endfunction

    assign wr_word    = 32'(s00_axi_awaddr[C_S00_AXI_ADDR_WIDTH-1:2]);
    assign rd_word    = 32'(s00_axi_araddr[C_S00_AXI_ADDR_WIDTH-1:2]);
    assign wr_fire    = aw_rdy & s00_axi_awvalid & s00_axi_wvalid;
    assign rd_fire    = ar_rdy & s00_axi_arvalid;
    assign wrap       = (cnt == period_act - cnt_t'(1));
    assign status_clr = wr_fire & (wr_word == 32'd2) & s00_axi_wstrb[0] & s00_axi_wdata[0];

    // ---------------- AXI handshakes ----------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_rdy <= 1'b0;
            b_vld  <= 1'b0;
            ar_rdy <= 1'b0;
            r_vld  <= 1'b0;
            r_data <= '0;
        end else begin
            aw_rdy <= ~aw_rdy & s00_axi_awvalid & s00_axi_wvalid & ~b_vld;
            if (wr_fire)
                b_vld <= 1'b1;
            else if (s00_axi_bready)
                b_vld <= 1'b0;

            ar_rdy <= ~ar_rdy & s00_axi_arvalid & ~r_vld;
            if (rd_fire) begin
                r_vld  <= 1'b1;
                r_data <= rd_mux;
            end else if (s00_axi_rready) begin
                r_vld  <= 1'b0;
            end
        end
    end

    assign s00_axi_awready = aw_rdy;
    assign s00_axi_wready  = aw_rdy;
    assign s00_axi_bvalid  = b_vld;
    assign s00_axi_bresp   = '0;
    assign s00_axi_arready = ar_rdy;
    assign s00_axi_rvalid  = r_vld;
    assign s00_axi_rdata   = r_data;
    assign s00_axi_rresp   = '0;

    // ---------------- register write path ----------------
    always_comb begin
        ctrl_en_new = ctrl_en;
        irq_en_new  = irq_en;
        if (s00_axi_wstrb[0]) ctrl_en_new = s00_axi_wdata[NUM_CH-1:0];
        if (s00_axi_wstrb[2]) irq_en_new  = s00_axi_wdata[16];

        period_new = merge_cnt(period_sh, s00_axi_wdata, s00_axi_wstrb);
        if (period_new < P_FLOOR) period_new = P_FLOOR;

        pulse_old = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (wr_word == 32'd4 + i) pulse_old = pulse_sh[i];
        end
        pulse_new = merge_cnt(pulse_old, s00_axi_wdata, s00_axi_wstrb);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ctrl_en   <= '0;
            irq_en    <= 1'b0;
            period_sh <= P_DEF;
            for (int unsigned i = 0; i < NUM_CH; i++) pulse_sh[i] <= '0;
        end else if (wr_fire) begin
            if (wr_word == 32'd0) begin
                ctrl_en <= ctrl_en_new;
                irq_en  <= irq_en_new;
            end
            if (wr_word == 32'd1) period_sh <= period_new;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (wr_word == 32'd4 + i) pulse_sh[i] <= pulse_new;
            end
        end
    end

    // ---------------- register read mux ----------------
    always_comb begin
        rd_mux = '0;
        case (rd_word)
            32'd0: begin
                rd_mux[NUM_CH-1:0] = ctrl_en;
                rd_mux[16]         = irq_en;
            end
            32'd1:   rd_mux[CNT_WIDTH-1:0] = period_sh;
            32'd2:   rd_mux[0]             = frame_done;
            32'd3:   rd_mux[CNT_WIDTH-1:0] = cnt;
            default: begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (rd_word == 32'd4 + i) rd_mux[CNT_WIDTH-1:0] = pulse_sh[i];
                end
            end
        endcase
    end

    // ---------------- frame counter and shadow transfer ----------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cnt        <= '0;
            period_act <= P_DEF;
            en_act     <= '0;
            frame_done <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) pulse_act[i] <= '0;
        end else if (wrap) begin
            cnt        <= '0;
            period_act <= period_sh;
            en_act     <= ctrl_en;
            frame_done <= 1'b1;  // set beats a same-cycle W1C
            for (int unsigned i = 0; i < NUM_CH; i++) pulse_act[i] <= clamp_pulse(pulse_sh[i]);
        end else begin
            cnt <= cnt + cnt_t'(1);
            if (status_clr) frame_done <= 1'b0;
        end
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pwm_q <= '0;
            irq_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) pwm_q[i] <= en_act[i] & (cnt < pulse_act[i]);
            irq_q <= frame_done & irq_en;
        end
    end

    assign pwm_out = pwm_q;
    assign irq     = irq_q;

endmodule
